// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared constants and types for the nibble-serial subtractor.
package nibble_sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result bus of the nibble-serial subtractor.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds valid (and its payload) until that edge;
// the consumer may change ready freely. Input side: in_valid/in_ready carry
// A, B, Bi. Output side: out_valid/out_ready carry D, Bo, Z, N, V, which are
// held stable while out_valid is 1 and out_ready is 0.
//
// Operand/result vectors are declared [0:WIDTH-1]; bit 0 is the LSB.
interface nibble_serial_subtractor_if
    import nibble_sub_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [0:WIDTH-1] A;
    logic [0:WIDTH-1] B;
    logic             Bi;
    logic             out_valid;
    logic             out_ready;
    logic [0:WIDTH-1] D;
    logic             Bo;
    logic             Z;
    logic             N;
    logic             V;
    state_t           state_dbg;

    modport master (
        output in_valid, A, B, Bi, out_ready,
        input  in_ready, out_valid, D, Bo, Z, N, V, state_dbg
    );

    modport slave (
        input  in_valid, A, B, Bi, out_ready,
        output in_ready, out_valid, D, Bo, Z, N, V, state_dbg
    );

endinterface

// File: rtl/nibble_serial_subtractor_fa.sv
// 4-bit full adder used as the nibble datapath: {o_co, o_s} = i_a + i_b + i_ci.
module fourBitFullAdder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_ci,
    output logic [3:0] o_s,
    output logic       o_co
);

    logic [4:0] w_sum;

    // Plain carry-propagating add; the subtractor feeds ~B and ~borrow.
    assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_ci};
    assign o_s   = w_sum[3:0];
    assign o_co  = w_sum[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor D = A - B - Bi, one nibble per clock, LSB nibble
// first, borrow chained between nibbles. Flags are registered on DONE entry.
module nibble_serial_subtractor
    import nibble_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    nibble_serial_subtractor_if.slave bus
);

    localparam int NUM_NIB = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
            $error("nibble_serial_subtractor: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t                               r_state;
    state_t                               w_next_state;
    logic                                 w_accept;
    logic                                 w_in_ready;
    logic                                 w_out_valid;
    logic                                 w_last;

    logic [NUM_NIB-1:0][NIBBLE_W-1:0]     r_a;
    logic [NUM_NIB-1:0][NIBBLE_W-1:0]     r_b;
    logic [NUM_NIB-1:0][NIBBLE_W-1:0]     r_d;
    logic [NUM_NIB-1:0][NIBBLE_W-1:0]     w_d_next;
    logic [IDX_W-1:0]                     r_idx;
    logic                                 r_borrow;
    logic                                 r_bo;
    logic                                 r_z;
    logic                                 r_n;
    logic                                 r_v;

    logic [WIDTH-1:0]                     w_a_le;
    logic [WIDTH-1:0]                     w_b_le;
    logic [WIDTH-1:0]                     w_d_le;
    logic [NIBBLE_W-1:0]                  w_a_nib;
    logic [NIBBLE_W-1:0]                  w_b_nib;
    logic [NIBBLE_W-1:0]                  w_sum;
    logic                                 w_co;
    logic                                 w_a_msb;
    logic                                 w_b_msb;
    logic                                 w_d_msb;

    // Map the bus bit order (bit 0 = LSB) onto internal descending vectors.
    always_comb begin
        w_a_le = '0;
        w_b_le = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_a_le[i] = bus.A[i];
            w_b_le[i] = bus.B[i];
        end
    end

    // Drive the result bus in the same bit order as the operands.
    always_comb begin
        bus.D = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bus.D[i] = w_d_le[i];
        end
    end

    assign w_d_le        = r_d;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.Bo        = r_bo;
    assign bus.Z         = r_z;
    assign bus.N         = r_n;
    assign bus.V         = r_v;
    assign bus.state_dbg = r_state;

    // Nibble datapath: A - B - borrow == A + ~B + ~borrow; carry out = no borrow.
    assign w_a_nib = r_a[r_idx];
    assign w_b_nib = r_b[r_idx];
    assign w_last  = (r_idx == LAST_IDX);

    fourBitFullAdder u_nibble_add (
        .i_a  (w_a_nib),
        .i_b  (~w_b_nib),
        .i_ci (~r_borrow),
        .o_s  (w_sum),
        .o_co (w_co)
    );

    // Difference as it will look after this cycle's nibble is written.
    always_comb begin
        w_d_next        = r_d;
        w_d_next[r_idx] = w_sum;
    end

    assign w_a_msb = r_a[NUM_NIB-1][NIBBLE_W-1];
    assign w_b_msb = r_b[NUM_NIB-1][NIBBLE_W-1];
    assign w_d_msb = w_d_next[NUM_NIB-1][NIBBLE_W-1];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and handshake outputs; in_ready only in IDLE, so no overlap.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand capture, per-nibble result/borrow update, flag capture on the last nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_idx    <= '0;
            r_borrow <= 1'b0;
            r_bo     <= 1'b0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
        end else if (w_accept) begin
            r_a      <= w_a_le;
            r_b      <= w_b_le;
            r_borrow <= bus.Bi;
            r_idx    <= '0;
        end else if (r_state == CALC) begin
            r_d      <= w_d_next;
            r_borrow <= ~w_co;
            r_idx    <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_bo <= ~w_co;
                r_z  <= (w_d_next == '0);
                r_n  <= w_d_msb;
                r_v  <= (w_a_msb != w_b_msb) && (w_d_msb != w_a_msb);
            end
        end
    end

endmodule
